// File: rtl/mips_pkg.sv
// Shared constants and FSM encoding for the sequential divider.
package mips_pkg;

  localparam int WIDTH = 32;

  // Quotient returned when the divisor is zero.
  localparam logic [WIDTH-1:0] DIV0_QUOTIENT = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } div_state_t;

endpackage : mips_pkg

// File: rtl/cond_negate32.sv
// Conditional two's-complement negation: o = neg ? -i : i.
module cond_negate32
  import mips_pkg::*;
(
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_val
);

  // Invert every bit under control of i_neg, then add i_neg to complete the negation.
  assign o_val = (i_val ^ {WIDTH{i_neg}}) + WIDTH'(i_neg);

endmodule : cond_negate32

// File: rtl/div32_seq.sv
// Sequential restoring divider (signed/unsigned), fixed 33-cycle latency.
// Operands are converted to magnitudes on accept, 32 restoring steps run in
// CALC, and FIX restores the result signs and registers the outputs.
module div32_seq #(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  import mips_pkg::*;

  // Counter value on the final restoring step.
  localparam logic [5:0] LAST_STEP = 6'(ITER - 1);

  div_state_t           r_state;
  logic [2*WIDTH-1:0]   r_acc;      // {partial remainder, dividend/quotient bits}
  logic [WIDTH-1:0]     r_dv_mag;
  logic                 r_q_neg;
  logic                 r_r_neg;
  logic                 r_zero;
  logic [5:0]           r_cnt;

  logic [WIDTH-1:0]     w_dd_mag;
  logic [WIDTH-1:0]     w_dv_mag;
  logic [WIDTH:0]       w_diff;
  logic                 w_fits;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic [WIDTH-1:0]     w_quo_fix;
  logic [WIDTH-1:0]     w_rem_fix;
  logic                 w_dd_neg;
  logic                 w_dv_neg;

  assign w_dd_neg = is_signed & dividend[WIDTH-1];
  assign w_dv_neg = is_signed & divisor[WIDTH-1];

  // Operand magnitudes, formed from the live inputs and captured on accept.
  cond_negate32 u_neg_dd (.i_val(dividend), .i_neg(w_dd_neg), .o_val(w_dd_mag));
  cond_negate32 u_neg_dv (.i_val(divisor),  .i_neg(w_dv_neg), .o_val(w_dv_mag));

  // One restoring step. The shifted remainder is 33 bits wide: its top bit
  // (r_acc MSB) set means it certainly exceeds the divisor, otherwise the
  // 33-bit subtractor's borrow decides. The low 32 difference bits are exact
  // whenever the step is taken because the new remainder is below the divisor.
  assign w_diff     = {1'b0, r_acc[2*WIDTH-2:WIDTH-1]} - {1'b0, r_dv_mag};
  assign w_fits     = r_acc[2*WIDTH-1] | ~w_diff[WIDTH];
  assign w_acc_next = w_fits ? {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                             : {r_acc[2*WIDTH-2:0], 1'b0};

  // Sign restoration; a zero magnitude is never negated.
  cond_negate32 u_neg_q (
    .i_val(r_acc[WIDTH-1:0]),
    .i_neg(r_q_neg & (|r_acc[WIDTH-1:0])),
    .o_val(w_quo_fix)
  );
  cond_negate32 u_neg_r (
    .i_val(r_acc[2*WIDTH-1:WIDTH]),
    .i_neg(r_r_neg & (|r_acc[2*WIDTH-1:WIDTH])),
    .o_val(w_rem_fix)
  );

  // Control FSM and datapath registers with registered outputs.
  // NOTE: every register here, including the wide datapath, is cleared by the
  // async reset so an aborted divide leaves no stale state behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_dv_mag    <= '0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_zero      <= 1'b0;
      r_cnt       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_acc    <= {{WIDTH{1'b0}}, w_dd_mag};
            r_dv_mag <= w_dv_mag;
            r_zero   <= (divisor == '0);
            // Divide-by-zero keeps an all-ones quotient, so its sign is forced positive;
            // the remainder path alone recreates the raw dividend.
            r_q_neg  <= (w_dd_neg ^ w_dv_neg) & (divisor != '0);
            r_r_neg  <= w_dd_neg;
            r_cnt    <= '0;
            busy     <= 1'b1;
            r_state  <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == LAST_STEP) begin
            r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          quotient    <= r_zero ? DIV0_QUOTIENT : w_quo_fix;
          remainder   <= w_rem_fix;
          div_by_zero <= r_zero;
          done        <= 1'b1;
          busy        <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule : div32_seq

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: directed cases with a result scoreboard.
module tb_div32_seq;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   busy_cnt = 0;

  always #5 clk = ~clk;

  div32_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour written directly from the arithmetic definition.
  function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.dz = 1'b0;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1;
    end else if (!s) begin
      e.q = a / b; e.r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000; e.r = 32'd0;
    end else begin
      e.q = 32'($signed(a) / $signed(b));
      e.r = 32'($signed(a) % $signed(b));
    end
    return e;
  endfunction

  function automatic exp_t mk(input logic [31:0] q, input logic [31:0] r, input logic dz);
    exp_t e;
    e.q = q; e.r = r; e.dz = dz;
    return e;
  endfunction

  // Drive a start from the current point (must be at a negedge); returns at the negedge after E0.
  task automatic launch_here(input logic s, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; is_signed = s; dividend = a; divisor = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    busy_cnt = busy ? 1 : 0;
  endtask

  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    launch_here(s, a, b);
  endtask

  // Wait (bounded) for done, counting edges after E0; optionally inject an ignored start.
  task automatic run_check(input string tag, input int inject_at);
    int   n;
    logic got;
    exp_t e;
    logic [31:0] q_hold;
    n = 0; got = 1'b0;
    q_hold = quotient;
    while (!got && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == inject_at) begin
        start = 1'b1; is_signed = 1'b1; dividend = 32'h0000_0040; divisor = 32'h0000_0003;
      end else if (n == inject_at + 1) begin
        start = 1'b0;
      end
      if (done) got = 1'b1;
      else begin
        if (busy) busy_cnt++;
        if (quotient !== q_hold) begin
          check({tag, "_hold"}, quotient, q_hold);
          q_hold = quotient;
        end
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, n, 33);
    check({tag, "_busy_cycles"}, busy_cnt, 33);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_q"}, quotient, e.q);
      check({tag, "_r"}, remainder, e.r);
      check({tag, "_dz"}, 32'(div_by_zero), 32'(e.dz));
    end
  endtask

  task automatic op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                    input exp_t e);
    exp_q.push_back(e);
    launch(s, a, b);
    run_check(tag, 0);
  endtask

  initial begin
    int quiet;
    logic [31:0] ra, rb;
    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    check("rst_dz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op("u100_7",   1'b0, 32'd100,        32'd7,          mk(32'd14, 32'd2, 1'b0));
    @(negedge clk);
    check("u100_7_done_pulse", 32'(done), 32'd0);
    check("u100_7_q_held", quotient, 32'd14);
    op("s_m7_2",   1'b1, 32'hFFFF_FFF9,  32'h0000_0002,  mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0));
    op("s_7_m2",   1'b1, 32'h0000_0007,  32'hFFFF_FFFE,  mk(32'hFFFF_FFFD, 32'd1, 1'b0));
    op("s_ovf",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  mk(32'h8000_0000, 32'd0, 1'b0));
    op("u_ovf",    1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  mk(32'd0, 32'h8000_0000, 1'b0));
    op("u_div0",   1'b0, 32'h1234_5678,  32'd0,          mk(32'hFFFF_FFFF, 32'h1234_5678, 1'b1));
    op("s_div0",   1'b1, 32'h1234_5678,  32'd0,          mk(32'hFFFF_FFFF, 32'h1234_5678, 1'b1));
    op("s_div0n",  1'b1, 32'h8765_4321,  32'd0,          mk(32'hFFFF_FFFF, 32'h8765_4321, 1'b1));
    op("u_big",    1'b0, 32'hFFFF_FFFF,  32'h8000_0001,  mk(32'd1, 32'h7FFF_FFFE, 1'b0));
    op("s_zero_q", 1'b1, 32'hFFFF_FFFD,  32'h0000_0005,  mk(32'd0, 32'hFFFF_FFFD, 1'b0));

    // Model-driven mixed cases
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i < 3) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (rb == 32'd0) rb = 32'd3;
      op("rand", 1'(i & 1), ra, rb, model(1'(i & 1), ra, rb));
    end

    // Start during busy is ignored; start in the done cycle is accepted.
    exp_q.push_back(mk(32'd14, 32'd2, 1'b0));
    launch(1'b0, 32'd100, 32'd7);
    run_check("busy_ign", 9);
    exp_q.push_back(model(1'b1, 32'hFFFF_FF00, 32'h0000_0007));
    launch_here(1'b1, 32'hFFFF_FF00, 32'h0000_0007);
    run_check("back2back", 0);

    // Reset mid-operation aborts with no done.
    launch(1'b0, 32'd1000, 32'd9);
    repeat (14) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_q", quotient, 32'd0);
    check("mid_rst_r", remainder, 32'd0);
    check("mid_rst_dz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) quiet++;
    end
    check("mid_rst_no_done", quiet, 0);
    op("after_rst", 1'b0, 32'd100, 32'd7, mk(32'd14, 32'd2, 1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule : tb_div32_seq

// File: doc/div32_seq.md
DIV32_SEQ -- requirements
Module: div32_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width; only 32 is verified.
REQ-002 SHALL have parameter ITER, default WIDTH, number of iteration cycles; fixed equal to WIDTH.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request a divide; sampled only in IDLE.
REQ-006 is_signed  input  1  1 = two's-complement divide (div), 0 = unsigned (divu); sampled with start.
REQ-007 dividend  input  WIDTH  numerator; sampled with start.
REQ-008 divisor  input  WIDTH  denominator; sampled with start.
REQ-009 busy  output  1  high while a divide is in progress.
REQ-010 done  output  1  one-cycle pulse, results valid.
REQ-011 quotient  output  WIDTH  LO result.
REQ-012 remainder  output  WIDTH  HI result.
REQ-013 div_by_zero  output  1  divisor was zero; valid with done, held until next accepted start.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIX.
REQ-015 IDLE: start=1 at edge E0 SHALL register operand magnitudes, result-sign flags and zero flag, clear the iteration counter, and enter CALC; busy=1 from E0.
REQ-016 CALC: one restoring step per cycle (shift remainder left by one and shift in the next dividend bit; trial-subtract the divisor magnitude; keep the difference if it is non-negative and set the quotient bit to 1, else restore and set it to 0); after 32 steps (E1..E32) SHALL enter FIX.
REQ-017 FIX (edge E33): SHALL apply signs, register quotient and remainder, pulse done=1 for exactly the cycle following E33, drop busy, and return to IDLE.
REQ-018 Latency SHALL be fixed at 33 cycles from the start edge to done, independent of operand values.
REQ-019 Signed mode: quotient sign = sign(dividend) XOR sign(divisor); remainder sign = sign(dividend); a zero result SHALL never be negated.
REQ-020 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0 (modulo-2^32 wrap, no flag).
REQ-021 Divisor 0, either mode: quotient 0xFFFFFFFF, remainder = raw dividend, div_by_zero=1; same 33-cycle latency.
REQ-022 start while busy SHALL be ignored, with no effect on the operation in progress.
REQ-023 start asserted in the done cycle SHALL be accepted; that cycle is IDLE.
REQ-024 quotient, remainder and div_by_zero SHALL hold their values between done pulses and SHALL NOT change during CALC.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and counter=0.
REQ-026 Reset mid-operation SHALL abort the divide with no done pulse; the first start after release SHALL behave as from power-up.

Structure
REQ-027 A shared package mips_pkg SHALL hold WIDTH, the FSM state encodings, and the DIV0_QUOTIENT constant (all ones).
REQ-028 Conditional two's-complement negation (bitwise XOR with control, then add control) SHALL be one sub-module, cond_negate32, instantiated for operand magnitude and result sign fix.
REQ-029 The datapath SHALL be a single 64-bit remainder/quotient shift register, a 33-bit subtractor, and a 6-bit counter; no multi-cycle paths are permitted.

Verification
REQ-030 Unsigned 100/7 -> quotient 14, remainder 2, div_by_zero 0, done exactly 33 cycles after start, busy high 33 cycles.
REQ-031 Signed -7/2 (0xFFFFFFF9/0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 7/-2 -> quotient 0xFFFFFFFD, remainder 1.
REQ-032 Signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0; unsigned same operands -> quotient 0, remainder 0x80000000.
REQ-033 Divisor 0 with dividend 0x12345678, both modes -> quotient 0xFFFFFFFF, remainder 0x12345678, div_by_zero 1 at cycle 33.
REQ-034 start pulsed with new operands at cycle 10 of a divide -> ignored, original result returned at cycle 33; start in the done cycle -> second result at 33 cycles later.
REQ-035 rst_n low at cycle 15 -> all outputs 0 immediately, no done; next divide of 100/7 -> correct result at 33 cycles.
